// File: rtl/ctrl_pipe_unit.sv
// Decode-and-carry control unit: decodes RISC-V opcode/funct7 into a 9-bit control
// bundle and carries it down NUM_STAGES registered stages with hold, flush and M-ext stall.
module ctrl_pipe_unit #(
   parameter int NUM_STAGES = 3,
   parameter int MC_LAT     = 4,
   parameter int CTRL_W     = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [6:0]                   opcode,
   input  logic [6:0]                   funct7,
   input  logic                         in_valid,
   input  logic                         ctrl_hold,
   input  logic                         ctrl_flush,
   output logic [NUM_STAGES*CTRL_W-1:0] ctrl_bus,
   output logic [NUM_STAGES-1:0]        stage_valid,
   output logic                         ctrl_stall,
   output logic                         mc_busy
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [3:0] MC_CNT_INIT = 4'(MC_LAT - 1);

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       reg_w;
      logic       mem_w;
      logic       mem_r;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
   } ctrl_t;

   ctrl_t                 r_stage [NUM_STAGES];
   logic [NUM_STAGES-1:0] r_valid;
   logic [3:0]            r_cnt;

   ctrl_t w_dec;
   logic  w_is_mc;

   // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      w_dec   = '0;
      w_is_mc = 1'b0;
      case (opcode)
         OPC_LOAD: begin
            w_dec.alu_src    = 1'b1;
            w_dec.reg_w      = 1'b1;
            w_dec.mem_r      = 1'b1;
            w_dec.mem_to_reg = 1'b1;
         end
         OPC_STORE: begin
            w_dec.alu_src = 1'b1;
            w_dec.mem_w   = 1'b1;
         end
         OPC_OP: begin
            w_dec.alu_op = 2'b10;
            w_dec.reg_w  = 1'b1;
            w_is_mc      = (MC_LAT > 1) && (funct7 == F7_MULDIV);
         end
         OPC_OP_IMM: begin
            w_dec.alu_op  = 2'b11;
            w_dec.alu_src = 1'b1;
            w_dec.reg_w   = 1'b1;
         end
         OPC_BRANCH: begin
            w_dec.alu_op = 2'b01;
            w_dec.branch = 1'b1;
         end
         OPC_JAL: begin
            w_dec.reg_w = 1'b1;
            w_dec.jump  = 1'b1;
         end
         default: w_dec = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples its
   // neighbour's pre-edge value regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_STAGES; k++) r_stage[k] <= '0;
         r_valid <= '0;
         r_cnt   <= '0;
      end else if (ctrl_flush) begin
         r_stage[0]   <= '0;
         r_stage[1]   <= '0;
         r_valid[1:0] <= '0;
         for (int k = 2; k < NUM_STAGES; k++) begin
            r_stage[k] <= r_stage[k-1];
            r_valid[k] <= r_valid[k-1];
         end
         r_cnt <= '0;
      end else if (!ctrl_hold) begin
         for (int k = 2; k < NUM_STAGES; k++) begin
            r_stage[k] <= r_stage[k-1];
            r_valid[k] <= r_valid[k-1];
         end
         if (r_cnt != 4'd0) begin
            // Multi-cycle op stays in stage 0; stage 1 receives bubbles meanwhile.
            r_stage[1] <= '0;
            r_valid[1] <= 1'b0;
            r_cnt      <= r_cnt - 4'd1;
         end else begin
            r_stage[1] <= r_stage[0];
            r_valid[1] <= r_valid[0];
            r_stage[0] <= in_valid ? w_dec : '0;
            r_valid[0] <= in_valid;
            r_cnt      <= (in_valid && w_is_mc) ? MC_CNT_INIT : 4'd0;
         end
      end
   end

   always_comb begin
      ctrl_bus = '0;
      for (int k = 0; k < NUM_STAGES; k++) ctrl_bus[k*CTRL_W +: CTRL_W] = r_stage[k];
   end

   assign stage_valid = r_valid;
   assign mc_busy     = (r_cnt != 4'd0);
   assign ctrl_stall  = ctrl_hold | mc_busy;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: two configurations (3 stages/MC_LAT 4 and 2 stages/MC_LAT 1)
// driven by directed and random stimulus, checked against a slot-and-residency reference model.
module tb_ctrl_pipe_unit;

   localparam int N0 = 3;
   localparam int L0 = 4;
   localparam int N1 = 2;
   localparam int L1 = 1;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam logic [6:0] F7_M   = 7'b0000001;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [6:0] opcode = '0, funct7 = '0;
   logic in_valid = 1'b0, ctrl_hold = 1'b0, ctrl_flush = 1'b0;

   logic [N0*9-1:0] bus0;
   logic [N0-1:0]   sv0;
   logic            stall0, busy0;
   logic [N1*9-1:0] bus1;
   logic [N1-1:0]   sv1;
   logic            stall1, busy1;

   ctrl_pipe_unit #(.NUM_STAGES(N0), .MC_LAT(L0), .CTRL_W(9)) u_dut0 (
      .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7), .in_valid(in_valid),
      .ctrl_hold(ctrl_hold), .ctrl_flush(ctrl_flush), .ctrl_bus(bus0),
      .stage_valid(sv0), .ctrl_stall(stall0), .mc_busy(busy0));

   ctrl_pipe_unit #(.NUM_STAGES(N1), .MC_LAT(L1), .CTRL_W(9)) u_dut1 (
      .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7), .in_valid(in_valid),
      .ctrl_hold(ctrl_hold), .ctrl_flush(ctrl_flush), .ctrl_bus(bus1),
      .stage_valid(sv1), .ctrl_stall(stall1), .mc_busy(busy1));

   always #5 clk = ~clk;

   // Model state: bundle per slot, valid per slot, and whether slot 0 holds a multi-cycle
   // op together with how many cycles it has already spent there.
   typedef struct packed {
      logic [3:0][8:0] st;
      logic [3:0]      v;
      logic            mc;
      logic [4:0]      age;
   } mstate_t;

   typedef struct packed {
      logic [N0*9-1:0] bus0;
      logic [N0-1:0]   v0;
      logic            busy0;
      logic [N1*9-1:0] bus1;
      logic [N1-1:0]   v1;
      logic            busy1;
   } snap_t;

   snap_t      state_q[$];
   logic [1:0] stall_q[$];
   mstate_t    m0 = '0, m1 = '0;
   logic       last_stall = 1'b0;
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] ref_bundle(input logic [6:0] opc);
      case (opc)
         LOAD:    return 9'h06C;
         STORE:   return 9'h050;
         OP:      return 9'h120;
         OPIMM:   return 9'h1E0;
         BRANCH:  return 9'h082;
         JAL:     return 9'h021;
         default: return 9'h000;
      endcase
   endfunction

   function automatic logic ref_busy(input mstate_t s, input int lat);
      return s.mc && (int'(s.age) < lat);
   endfunction

   function automatic mstate_t ref_next(input mstate_t s, input int n, input int lat,
                                        input logic [6:0] opc, input logic [6:0] f7,
                                        input logic iv, input logic hold, input logic flush);
      mstate_t r;
      r = s;
      if (flush || !hold) begin
         for (int k = 2; k < n; k++) begin
            r.st[k] = s.st[k-1];
            r.v[k]  = s.v[k-1];
         end
      end
      if (flush) begin
         r.st[0] = '0; r.v[0] = 1'b0;
         r.st[1] = '0; r.v[1] = 1'b0;
         r.mc    = 1'b0;
         r.age   = '0;
      end else if (!hold && ref_busy(s, lat)) begin
         r.st[1] = '0; r.v[1] = 1'b0;
         r.age   = s.age + 5'd1;
      end else if (!hold) begin
         r.st[1] = s.st[0]; r.v[1] = s.v[0];
         r.st[0] = iv ? ref_bundle(opc) : 9'h000;
         r.v[0]  = iv;
         r.mc    = iv && (opc == OP) && (f7 == F7_M);
         r.age   = 5'd1;
      end
      return r;
   endfunction

   function automatic snap_t mk_snap(input mstate_t a, input mstate_t b);
      snap_t s;
      s.bus0  = a.st[N0-1:0];
      s.v0    = a.v[N0-1:0];
      s.busy0 = ref_busy(a, L0);
      s.bus1  = b.st[N1-1:0];
      s.v1    = b.v[N1-1:0];
      s.busy1 = ref_busy(b, L1);
      return s;
   endfunction

   task automatic drive(input logic [6:0] opc, input logic [6:0] f7, input logic iv,
                        input logic hold, input logic flush);
      opcode = opc; funct7 = f7; in_valid = iv; ctrl_hold = hold; ctrl_flush = flush;
      last_stall = hold | ref_busy(m0, L0);
      stall_q.push_back({hold | ref_busy(m0, L0), hold | ref_busy(m1, L1)});
      m0 = ref_next(m0, N0, L0, opc, f7, iv, hold, flush);
      m1 = ref_next(m1, N1, L1, opc, f7, iv, hold, flush);
      state_q.push_back(mk_snap(m0, m1));
   endtask

   task automatic step(input logic [6:0] opc, input logic [6:0] f7, input logic iv,
                       input logic hold, input logic flush);
      @(negedge clk);
      drive(opc, f7, iv, hold, flush);
   endtask

   // Registered outputs, compared just after each rising edge.
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (state_q.size() != 0) begin
            e = state_q.pop_front();
            check("bus0", 64'(bus0), 64'(e.bus0));
            check("valid0", 64'(sv0), 64'(e.v0));
            check("mc_busy0", 64'(busy0), 64'(e.busy0));
            check("bus1", 64'(bus1), 64'(e.bus1));
            check("valid1", 64'(sv1), 64'(e.v1));
            check("mc_busy1", 64'(busy1), 64'(e.busy1));
         end
      end
   end

   // Combinational stall, compared after the inputs of the cycle settle.
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (stall_q.size() != 0) begin
            e = stall_q.pop_front();
            check("stall0", 64'(stall0), 64'(e[1]));
            check("stall1", 64'(stall1), 64'(e[0]));
         end
      end
   end

   initial begin
      logic [6:0] opc, f7;
      logic [6:0] tbl [6];
      int sel;
      tbl = '{LOAD, STORE, OP, OPIMM, BRANCH, JAL};
      opc = '0;
      f7  = '0;

      // Reset state, with ctrl_stall following ctrl_hold while in reset.
      #1 rst = 1'b1;
      ctrl_hold = 1'b1;
      #2;
      check("rst_bus0", 64'(bus0), 64'h0);
      check("rst_valid0", 64'(sv0), 64'h0);
      check("rst_busy0", 64'(busy0), 64'h0);
      check("rst_stall_hold", 64'(stall0), 64'h1);
      ctrl_hold = 1'b0;
      #1;
      check("rst_stall_nohold", 64'(stall0), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(LOAD, 7'h00, 1'b1, 1'b0, 1'b0);

      // Decode table on consecutive cycles, then unknown opcode and a bubble.
      step(STORE, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OPIMM, 7'h00, 1'b1, 1'b0, 1'b0);
      step(BRANCH, 7'h00, 1'b1, 1'b0, 1'b0);
      step(JAL, 7'h00, 1'b1, 1'b0, 1'b0);
      step(SYSTEM, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b0, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b0, 1'b0, 1'b0);

      // MUL then ADD, upstream keeping ADD steady while stalled.
      step(OP, F7_M, 1'b1, 1'b0, 1'b0);
      repeat (4) step(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b0, 1'b0, 1'b0);

      // Two-cycle hold mid-stream, then hold during a MUL.
      step(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      step(BRANCH, 7'h00, 1'b1, 1'b1, 1'b0);
      step(BRANCH, 7'h00, 1'b1, 1'b1, 1'b0);
      step(BRANCH, 7'h00, 1'b1, 1'b0, 1'b0);
      step(JAL, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, F7_M, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b1, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b1, 1'b0);
      repeat (4) step(OP, 7'h00, 1'b1, 1'b0, 1'b0);

      // Flush with ADD in stage 0, BRANCH in stage 1 and ADD incoming; then the same under hold.
      step(BRANCH, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b0, 1'b1);
      step(OP, 7'h00, 1'b0, 1'b0, 1'b0);
      step(BRANCH, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b1, 1'b1);
      step(OP, 7'h00, 1'b0, 1'b0, 1'b0);

      // Flush on the final multi-cycle cycle kills the op.
      step(OP, F7_M, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b0, 1'b1);
      step(JAL, 7'h00, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset while a MUL is mid-residency.
      step(OP, F7_M, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_bus0", 64'(bus0), 64'h0);
      check("async_rst_valid0", 64'(sv0), 64'h0);
      check("async_rst_busy0", 64'(busy0), 64'h0);
      check("async_rst_stall0", 64'(stall0), 64'h0);
      m0 = '0;
      m1 = '0;
      @(negedge clk);
      rst = 1'b0;
      drive(OP, 7'h00, 1'b1, 1'b0, 1'b0);
      step(OP, 7'h00, 1'b0, 1'b0, 1'b0);

      // Random traffic from an upstream that holds its instruction while stalled.
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            sel = $urandom_range(0, 8);
            f7  = 7'($urandom_range(0, 127));
            if (sel < 6) opc = tbl[sel];
            else if (sel == 6) opc = SYSTEM;
            else if (sel == 7) opc = 7'($urandom_range(0, 127));
            else begin
               opc = OP;
               f7  = F7_M;
            end
         end
         step(opc, f7, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 11) == 0));
      end

      repeat (3) @(negedge clk);
      check("drain_state_q", 64'(state_q.size()), 64'h0);
      check("drain_stall_q", 64'(stall_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
